// File: rtl/dff_pkg.sv
// Shared definitions for the dff_pipe elastic register pipeline.
package dff_pkg;

    localparam logic DFF_RST_DATA = '0;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: a WIDTH-bit data register plus its valid bit.
module dff_pipe_stage
    import dff_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             load,
    output logic             vld,
    output logic [WIDTH-1:0] data
);

    // Data only moves with a real beat, so an empty stage keeps its last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld  <= 1'b0;
            data <= {WIDTH{DFF_RST_DATA}};
        end else if (clear) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= up_valid;
            if (up_valid)
                data <= up_data;
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready on both ends and bubble collapsing.
// Optional registered occupancy counter: define DFF_PIPE_COUNT_EN.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
`ifdef DFF_PIPE_COUNT_EN
    output logic [cnt_w(DEPTH)-1:0]  occupancy,
`endif
    output logic [WIDTH-1:0]         out_data_n
);

    logic             vld  [DEPTH];
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] can_load;

    // The recursive ready chain is flattened: stage i may load when out_ready
    // is high or any stage from i to the output end is empty.
    always_comb begin
        logic hole;
        can_load = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hole = 1'b0;
            for (int unsigned j = i; j < DEPTH; j++)
                hole = hole | ~vld[j];
            can_load[i] = hole | out_ready;
        end
    end

    assign in_ready = can_load[0] & ~clear;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;

        if (gi == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_body
            assign up_valid = vld[gi-1];
            assign up_data  = data[gi-1];
        end

        dff_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .clear   (clear),
            .up_valid(up_valid),
            .up_data (up_data),
            .load    (can_load[gi]),
            .vld     (vld[gi]),
            .data    (data[gi])
        );
    end

    assign out_valid  = vld[DEPTH-1];
    assign out_data   = data[DEPTH-1];
    assign out_data_n = ~data[DEPTH-1];

`ifdef DFF_PIPE_COUNT_EN
    localparam int CW = cnt_w(DEPTH);

    logic push;
    logic pop;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            occupancy <= '0;
        else if (clear)
            occupancy <= '0;
        else if (push & ~pop)
            occupancy <= occupancy + CW'(1);
        else if (pop & ~push)
            occupancy <= occupancy - CW'(1);
    end
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: beat-position model plus push/pop scoreboard, and directed literal checks.
module tb_dff_pipe #(
    parameter int DEPTH = 4
);
    localparam int W  = 8;
    localparam int CW = $clog2(DEPTH + 1);

    logic         clk = 1'b0;
    logic         reset_n;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [W-1:0] out_data_n;
`ifdef DFF_PIPE_COUNT_EN
    logic [CW-1:0] occupancy;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dff_pipe #(
        .WIDTH(W),
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef DFF_PIPE_COUNT_EN
        .occupancy (occupancy),
`endif
        .out_data_n(out_data_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: each beat in flight carries its stage position; a beat moves one
    // stage per cycle but can never reach or pass the beat ahead of it.
    typedef struct {
        logic [W-1:0] d;
        int           pos;
    } beat_t;

    beat_t        q[$];
    logic [W-1:0] sent_q[$];
    logic [W-1:0] last_end = '0;

    function automatic bit head_at_end();
        return (q.size() > 0) && (q[0].pos == DEPTH - 1);
    endfunction

    function automatic bit model_ready();
        int lim = DEPTH;
        int np;
        if (clear) return 1'b0;
        for (int k = 0; k < q.size(); k++) begin
            if (k == 0 && q[0].pos == DEPTH - 1 && out_ready) begin
                lim = DEPTH;
            end else begin
                np = q[k].pos + 1;
                if (np > lim - 1) np = lim - 1;
                lim = np;
            end
        end
        return lim >= 1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        bit pop_m, push_m;
        int lim, np;
        if (!reset_n) begin
            q.delete();
            sent_q.delete();
            last_end = '0;
        end else begin
            pop_m  = head_at_end() && out_ready;
            push_m = in_valid && model_ready();
            if (pop_m) void'(q.pop_front());
            if (clear) begin
                q.delete();
            end else begin
                lim = DEPTH;
                for (int k = 0; k < q.size(); k++) begin
                    np = q[k].pos + 1;
                    if (np > lim - 1) np = lim - 1;
                    q[k].pos = np;
                    lim = np;
                    if (np == DEPTH - 1) last_end = q[k].d;
                end
                if (push_m) begin
                    q.push_back('{d: in_data, pos: 0});
                    if (DEPTH == 1) last_end = in_data;
                end
            end
        end
    end

    // Compare process: every cycle out of reset, away from the active edge.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
            chk("out_valid", {31'd0, out_valid}, {31'd0, head_at_end()});
            chk("out_data", {24'd0, out_data}, {24'd0, last_end});
            chk("out_data_n", {24'd0, out_data_n}, {24'd0, ~last_end});
`ifdef DFF_PIPE_COUNT_EN
            chk("occupancy", 32'(occupancy), 32'(q.size()));
`endif
            if (out_valid && out_ready) begin
                if (sent_q.size() == 0) begin
                    chk("pop_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("pop_order", {24'd0, out_data}, {24'd0, sent_q[0]});
                    void'(sent_q.pop_front());
                end
            end
            if (clear) sent_q.delete();
            else if (in_valid && in_ready) sent_q.push_back(in_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_data"}, {24'd0, out_data}, 32'h00);
        chk({tag, "_out_data_n"}, {24'd0, out_data_n}, 32'hFF);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
`ifdef DFF_PIPE_COUNT_EN
        chk({tag, "_occupancy"}, 32'(occupancy), 32'd0);
`endif
    endtask

    task automatic load_held(input logic [W-1:0] base, input int n);
        out_ready = 1'b0;
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = base + W'(k);
            step();
        end
        idle(DEPTH);
    endtask

    initial begin
        int nsent, ngot, first, held;
        logic [W-1:0] exp_next;

        reset_n   = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        check_reset_vals("init");
        step();
        step();
        reset_n = 1'b1;
        step();

        // Streaming: 16 beats back to back with out_ready held high.
        out_ready = 1'b1;
        nsent = 0;
        ngot  = 0;
        first = -1;
        for (int c = 1; c <= 60 && ngot < 16; c++) begin
            in_valid = (nsent < 16);
            in_data  = W'(nsent + 1);
            if (in_valid && in_ready) nsent++;
            step();
            if (out_valid) begin
                if (first < 0) begin
                    first = c;
                    chk("stream_latency", 32'(first), 32'(DEPTH));
                end
                chk("stream_data", {24'd0, out_data}, 32'(ngot + 1));
                chk("stream_consecutive", 32'(c), 32'(first + ngot));
                ngot++;
            end
        end
        chk("stream_count", 32'(ngot), 32'd16);
        idle(DEPTH + 2);

        // Fill until full with the consumer stalled.
        out_ready = 1'b0;
        for (int k = 0; k <= DEPTH; k++) begin
            in_valid = 1'b1;
            in_data  = 8'hA0 + W'(k);
            chk("fill_in_ready", {31'd0, in_ready}, (k < DEPTH) ? 32'd1 : 32'd0);
            step();
        end
        in_valid = 1'b0;
        chk("full_out_valid", {31'd0, out_valid}, 32'd1);
        chk("full_out_data", {24'd0, out_data}, 32'hA0);
`ifdef DFF_PIPE_COUNT_EN
        chk("full_occupancy", 32'(occupancy), 32'(DEPTH));
`endif

        // Full: push and pop in the same cycle.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hB0;
        #1;
        chk("fullpp_in_ready", {31'd0, in_ready}, 32'd1);
        chk("fullpp_pop_data", {24'd0, out_data}, 32'hA0);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_next  = (DEPTH > 1) ? 8'hA1 : 8'hB0;
        chk("fullpp_next_data", {24'd0, out_data}, {24'd0, exp_next});
`ifdef DFF_PIPE_COUNT_EN
        chk("fullpp_occupancy", 32'(occupancy), 32'(DEPTH));
`endif
        out_ready = 1'b1;
        idle(DEPTH + 2);
        chk("drained_out_valid", {31'd0, out_valid}, 32'd0);

        // Random stall traffic, checked by the model every cycle.
        for (int c = 0; c < 1000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = W'($urandom);
            step();
        end
        out_ready = 1'b1;
        idle(DEPTH + 2);
        chk("random_drained", 32'(sent_q.size()), 32'd0);

        // Clear with beats held: one pop completes, the input beat is refused.
        held = (DEPTH < 3) ? DEPTH : 3;
        load_held(8'hC0, held);
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hCF;
        out_ready = 1'b1;
        #1;
        chk("clear_in_ready", {31'd0, in_ready}, 32'd0);
        chk("clear_pop_valid", {31'd0, out_valid}, 32'd1);
        chk("clear_pop_data", {24'd0, out_data}, 32'hC0);
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clear_out_valid", {31'd0, out_valid}, 32'd0);
        chk("clear_data_kept", {24'd0, out_data}, 32'hC0);
`ifdef DFF_PIPE_COUNT_EN
        chk("clear_occupancy", 32'(occupancy), 32'd0);
`endif
        idle(DEPTH + 1);
        chk("clear_no_push", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-stream with beats held.
        load_held(8'hD0, held);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        step();
        check_reset_vals("rst_hold");
        reset_n = 1'b1;
        idle(DEPTH + 1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
